// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs a single-outstanding
// request/grant/rvalid handshake and buffers responses in a 2-entry FIFO.
module fetch_ctrl #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [ADDR_WIDTH-1:0] boot_addr_i,
   input  logic                  fetch_enable_i,
   output logic                  instr_req_o,
   output logic [ADDR_WIDTH-1:0] instr_addr_o,
   input  logic                  instr_gnt_i,
   input  logic                  instr_rvalid_i,
   input  logic [31:0]           instr_rdata_i,
   input  logic                  instr_err_i,
   input  logic                  branch_i,
   input  logic [ADDR_WIDTH-1:0] branch_target_i,
   input  logic                  id_ready_i,
   output logic                  instr_valid_o,
   output logic [31:0]           instr_o,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic                  instr_err_o,
   output logic                  busy_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  started_q, started_d;
   logic                  discard_q, discard_d;

   logic [31:0]           fifo_instr [2];
   logic [ADDR_WIDTH-1:0] fifo_pc    [2];
   logic                  fifo_err   [2];
   logic                  wr_ptr_q, rd_ptr_q;
   logic [1:0]            count_q, count_d;
   logic                  push, pop;

   // A redirect flushes the FIFO, so it also suppresses any same-cycle push or pop.
   assign push    = (state_q == S_WAIT) && instr_rvalid_i && !discard_q && !branch_i;
   assign pop     = id_ready_i && instr_valid_o && !branch_i;
   assign count_d = branch_i ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      addr_d    = addr_q;
      started_d = started_q;
      discard_d = discard_q;
      case (state_q)
         S_IDLE: begin
            if (fetch_enable_i && (count_q < 2'd2)) begin
               state_d   = S_REQ;
               started_d = 1'b1;
               if (!started_q) begin
                  pc_d = boot_addr_i;
               end
            end
         end
         S_REQ: begin
            if (instr_gnt_i) begin
               addr_d  = pc_q;
               pc_d    = pc_q + ADDR_WIDTH'(4);
               state_d = S_WAIT;
               if (branch_i) begin
                  discard_d = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (instr_rvalid_i) begin
               discard_d = 1'b0;
               state_d   = (fetch_enable_i && (count_d < 2'd2)) ? S_REQ : S_IDLE;
            end else if (branch_i) begin
               discard_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Redirect target wins over both the boot load and the +4 increment.
      if (branch_i) begin
         pc_d = branch_target_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         addr_q    <= '0;
         started_q <= 1'b0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         addr_q    <= addr_d;
         started_q <= started_d;
         discard_q <= discard_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         count_q       <= 2'd0;
         fifo_instr[0] <= '0;
         fifo_instr[1] <= '0;
         fifo_pc[0]    <= '0;
         fifo_pc[1]    <= '0;
         fifo_err[0]   <= 1'b0;
         fifo_err[1]   <= 1'b0;
      end else begin
         count_q <= count_d;
         if (branch_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
         end else begin
            if (push) begin
               fifo_instr[wr_ptr_q] <= instr_rdata_i;
               fifo_pc[wr_ptr_q]    <= addr_q;
               fifo_err[wr_ptr_q]   <= instr_err_i;
               wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
               rd_ptr_q <= ~rd_ptr_q;
            end
         end
      end
   end

   assign instr_req_o   = (state_q == S_REQ);
   assign instr_addr_o  = pc_q;
   assign busy_o        = (state_q != S_IDLE);
   assign instr_valid_o = (count_q != 2'd0);
   assign instr_o       = fifo_instr[rd_ptr_q];
   assign pc_o          = fifo_pc[rd_ptr_q];
   assign instr_err_o   = fifo_err[rd_ptr_q];

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a behavioural RAM responder plus a program-order
// stream model of what decode must see, driven from scenario tasks.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] boot_addr;
   logic        fetch_enable;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        instr_gnt;
   logic        instr_rvalid;
   logic [31:0] instr_rdata;
   logic        instr_err;
   logic        branch;
   logic [31:0] branch_target;
   logic        id_ready;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        err_out;
   logic        busy;

   always #5 clk = ~clk;

   fetch_ctrl #(.ADDR_WIDTH(32)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .boot_addr_i    (boot_addr),
      .fetch_enable_i (fetch_enable),
      .instr_req_o    (instr_req),
      .instr_addr_o   (instr_addr),
      .instr_gnt_i    (instr_gnt),
      .instr_rvalid_i (instr_rvalid),
      .instr_rdata_i  (instr_rdata),
      .instr_err_i    (instr_err),
      .branch_i       (branch),
      .branch_target_i(branch_target),
      .id_ready_i     (id_ready),
      .instr_valid_o  (instr_valid),
      .instr_o        (instr_out),
      .pc_o           (pc_out),
      .instr_err_o    (err_out),
      .busy_o         (busy)
   );

   int total = 0;
   int bad   = 0;

   // Stream model: the next program-order PC decode must receive.
   logic [31:0] exp_pc;
   int          n_pop;
   int          cyc;
   int          last_pop_cyc;
   int          pop_gap;
   logic [31:0] last_pop_pc;
   logic        last_pop_err;
   logic        just_popped;

   logic        last_req, last_valid, last_busy;
   logic [31:0] last_addr;
   logic        en;

   // RAM responder state.
   logic [31:0] gnt_log [$];
   logic        just_granted;
   logic        rand_lat;
   int          gfix, rfix;
   int          gnt_cnt;
   logic        pend;
   logic [31:0] pend_addr;
   int          pend_cnt;
   logic        bog_arm, bog_hit;
   logic [31:0] bog_addr, bog_tgt;

   function automatic logic [31:0] ram_data(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   function automatic logic ram_err(input logic [31:0] a);
      return (a[6:2] == 5'd3);
   endfunction

   task automatic step(input logic ready, input logic br, input logic [31:0] tgt);
      logic        do_br;
      logic [31:0] t;
      logic        gnt_v, rv_v, err_v;
      logic [31:0] rdata_v;
      do_br = br;
      t     = tgt;
      @(negedge clk);
      cyc++;
      last_req     = instr_req;
      last_addr    = instr_addr;
      last_valid   = instr_valid;
      last_busy    = busy;
      just_granted = 1'b0;
      just_popped  = 1'b0;
      rv_v    = 1'b0;
      rdata_v = $urandom;
      err_v   = 1'($urandom_range(0, 1));
      if (pend) begin
         if (pend_cnt == 0) begin
            rv_v    = 1'b1;
            rdata_v = ram_data(pend_addr);
            err_v   = ram_err(pend_addr);
            pend    = 1'b0;
         end else begin
            pend_cnt--;
         end
      end
      gnt_v = 1'b0;
      if (instr_req === 1'b1) begin
         if (gnt_cnt < 0) gnt_cnt = rand_lat ? int'($urandom_range(0, 2)) : gfix;
         if (gnt_cnt == 0) begin
            gnt_v        = 1'b1;
            gnt_cnt      = -1;
            pend         = 1'b1;
            pend_addr    = instr_addr;
            pend_cnt     = rand_lat ? int'($urandom_range(0, 2)) : rfix;
            just_granted = 1'b1;
            gnt_log.push_back(instr_addr);
            if (bog_arm && instr_addr == bog_addr) begin
               do_br   = 1'b1;
               t       = bog_tgt;
               bog_arm = 1'b0;
               bog_hit = 1'b1;
            end
         end else begin
            gnt_cnt--;
         end
      end
      if (ready && instr_valid === 1'b1 && !do_br) begin
         total++;
         if (pc_out !== exp_pc || instr_out !== ram_data(exp_pc) || err_out !== ram_err(exp_pc)) begin
            bad++;
            $display("[TB] FAIL pop_stream: pc=%h instr=%h err=%b, expected pc=%h instr=%h err=%b",
                     pc_out, instr_out, err_out, exp_pc, ram_data(exp_pc), ram_err(exp_pc));
         end
         last_pop_pc  = pc_out;
         last_pop_err = err_out;
         pop_gap      = cyc - last_pop_cyc;
         last_pop_cyc = cyc;
         just_popped  = 1'b1;
         n_pop++;
         exp_pc = exp_pc + 32'd4;
      end
      if (do_br) exp_pc = t;
      instr_gnt     = gnt_v;
      instr_rvalid  = rv_v;
      instr_rdata   = rdata_v;
      instr_err     = err_v;
      id_ready      = ready;
      branch        = do_br;
      branch_target = do_br ? t : $urandom;
      fetch_enable  = en;
   endtask

   task automatic drain_to_idle(input string name);
      logic found;
      en    = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b0, 32'h0);
         if (last_busy === 1'b0 && !pend) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (!found) begin
         bad++;
         $display("[TB] FAIL %s_drain: busy still %b after 40 cycles, expected 0", name, last_busy);
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      boot_addr     = 32'h0000_0080;
      fetch_enable  = 1'b1;
      instr_gnt     = 1'b0;
      instr_rvalid  = 1'b0;
      instr_rdata   = 32'h0;
      instr_err     = 1'b0;
      branch        = 1'b0;
      branch_target = 32'h0;
      id_ready      = 1'b1;
      en = 1'b0; rand_lat = 1'b0; gfix = 0; rfix = 0; gnt_cnt = -1; pend = 1'b0;
      bog_arm = 1'b0; bog_hit = 1'b0; cyc = 0; n_pop = 0; last_pop_cyc = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (instr_req !== 1'b0)   begin bad++; $display("[TB] FAIL reset_req: got %b want 0", instr_req); end
      total++; if (instr_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_addr: got %h want 0", instr_addr); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", instr_valid); end
      total++; if (instr_out !== 32'h0)  begin bad++; $display("[TB] FAIL reset_instr: got %h want 0", instr_out); end
      total++; if (pc_out !== 32'h0)     begin bad++; $display("[TB] FAIL reset_pc: got %h want 0", pc_out); end
      total++; if (err_out !== 1'b0)     begin bad++; $display("[TB] FAIL reset_err: got %b want 0", err_out); end
      total++; if (busy !== 1'b0)        begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      fetch_enable = 1'b0;
      rst_n        = 1'b1;
   endtask

   task automatic test_boot_fetch();
      logic found;
      gnt_log.delete();
      n_pop  = 0;
      exp_pc = 32'h0000_0080;
      en     = 1'b1;
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      total++;
      if (last_req !== 1'b1 || last_addr !== 32'h80) begin
         bad++;
         $display("[TB] FAIL boot_first_req: req=%b addr=%h, want req=1 addr=00000080", last_req, last_addr);
      end
      total++; if (last_busy !== 1'b1) begin bad++; $display("[TB] FAIL boot_busy: got %b want 1", last_busy); end
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b0, 32'h0);
         if (just_granted) begin
            total++;
            if (gnt_log[gnt_log.size()-1] !== 32'h80 + 32'(4 * (gnt_log.size() - 1))) begin
               bad++;
               $display("[TB] FAIL boot_req_addr: got %h want %h", gnt_log[gnt_log.size()-1],
                        32'h80 + 32'(4 * (gnt_log.size() - 1)));
            end
         end
         if (just_popped && n_pop >= 2) begin
            total++;
            if (pop_gap != 2) begin bad++; $display("[TB] FAIL boot_throughput: gap %0d want 2", pop_gap); end
         end
         if (n_pop == 3) begin found = 1'b1; break; end
      end
      total++;
      if (!found) begin bad++; $display("[TB] FAIL boot_timeout: %0d pops, want 3", n_pop); end
   endtask

   task automatic test_back_pressure();
      int g_stall, p0;
      logic found;
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 1'b0, 32'h0);
         if (i >= 6) begin
            total++;
            if (last_req !== 1'b0) begin bad++; $display("[TB] FAIL stall_req: got %b want 0", last_req); end
         end
      end
      total++;
      if (gnt_log.size() - n_pop != 2) begin
         bad++;
         $display("[TB] FAIL stall_buffered: got %0d want 2", gnt_log.size() - n_pop);
      end
      total++; if (last_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid: got %b want 1", last_valid); end
      g_stall = gnt_log.size();
      p0      = n_pop;
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      total++;
      if (n_pop != p0 + 2) begin bad++; $display("[TB] FAIL release_b2b: got %0d pops want 2", n_pop - p0); end
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (gnt_log.size() > g_stall) begin found = 1'b1; break; end
         step(1'b1, 1'b0, 32'h0);
      end
      total++;
      if (!found || gnt_log[g_stall] !== 32'h80 + 32'(4 * g_stall)) begin
         bad++;
         $display("[TB] FAIL resume_addr: got %h want %h", found ? gnt_log[g_stall] : 32'hx, 32'h80 + 32'(4 * g_stall));
      end
   endtask

   task automatic test_redirect_wait();
      logic found;
      int gi, p0;
      rand_lat = 1'b0; gfix = 0; rfix = 1;
      step(1'b1, 1'b1, 32'h88);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step(1'b1, 1'b0, 32'h0);
         if (just_granted && gnt_log[gnt_log.size()-1] == 32'h90) begin found = 1'b1; break; end
      end
      total++;
      if (!found) begin bad++; $display("[TB] FAIL redir_wait_setup: no grant for 00000090"); end
      step(1'b1, 1'b1, 32'h200);
      gi = gnt_log.size();
      p0 = n_pop;
      step(1'b1, 1'b0, 32'h0);
      total++; if (last_valid !== 1'b0) begin bad++; $display("[TB] FAIL redir_wait_flush: valid %b want 0", last_valid); end
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 32'h0);
         if (n_pop > p0) begin found = 1'b1; break; end
      end
      total++;
      if (!found || gnt_log[gi] !== 32'h200 || last_pop_pc !== 32'h200) begin
         bad++;
         $display("[TB] FAIL redir_wait_target: req=%h pc=%h want 00000200", found ? gnt_log[gi] : 32'hx, last_pop_pc);
      end
   endtask

   task automatic test_redirect_grant();
      logic found;
      int gi, p0;
      rand_lat = 1'b0; gfix = 0; rfix = 1;
      step(1'b1, 1'b1, 32'h40);
      bog_arm = 1'b1; bog_hit = 1'b0; bog_addr = 32'h40; bog_tgt = 32'h1000;
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step(1'b1, 1'b0, 32'h0);
         if (bog_hit) begin found = 1'b1; break; end
      end
      bog_arm = 1'b0;
      total++;
      if (!found) begin bad++; $display("[TB] FAIL redir_grant_setup: no grant for 00000040"); end
      gi = gnt_log.size();
      p0 = n_pop;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 32'h0);
         if (n_pop > p0) begin found = 1'b1; break; end
      end
      total++;
      if (!found || gnt_log[gi] !== 32'h1000) begin
         bad++;
         $display("[TB] FAIL redir_grant_req: got %h want 00001000", found ? gnt_log[gi] : 32'hx);
      end
      total++;
      if (last_pop_pc !== 32'h1000) begin bad++; $display("[TB] FAIL redir_grant_pc: got %h want 00001000", last_pop_pc); end
   endtask

   task automatic test_wait_wrap();
      logic found, first_done;
      int hold;
      drain_to_idle("wrap");
      step(1'b1, 1'b1, 32'hFFFF_FFFC);
      rand_lat = 1'b0; gfix = 3; rfix = 0;
      en = 1'b1;
      hold = 0; first_done = 1'b0; found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step(1'b1, 1'b0, 32'h0);
         if (!first_done && last_req === 1'b1) begin
            hold++;
            total++;
            if (last_addr !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_hold_addr: got %h want fffffffc", last_addr); end
            if (just_granted) first_done = 1'b1;
         end else if (first_done && just_granted) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (hold != 4) begin bad++; $display("[TB] FAIL wrap_hold_cycles: got %0d want 4", hold); end
      total++;
      if (!found || gnt_log[gnt_log.size()-1] !== 32'h0) begin
         bad++;
         $display("[TB] FAIL wrap_next_addr: got %h want 00000000", gnt_log[gnt_log.size()-1]);
      end
   endtask

   task automatic test_disable_error();
      logic found, granted;
      int p0, g0;
      rand_lat = 1'b0; gfix = 0; rfix = 0;
      drain_to_idle("disable");
      step(1'b1, 1'b1, 32'h10C);
      gfix = 2; rfix = 1;
      en = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 32'h0);
         if (last_req === 1'b1) begin found = 1'b1; break; end
      end
      en = 1'b0;
      p0 = n_pop;
      granted = just_granted;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 32'h0);
         if (!granted) begin
            total++;
            if (last_req !== 1'b1) begin bad++; $display("[TB] FAIL disable_req_held: got %b want 1", last_req); end
            if (just_granted) granted = 1'b1;
         end
         if (n_pop > p0) begin found = 1'b1; break; end
      end
      total++;
      if (!found || last_pop_pc !== 32'h10C || last_pop_err !== 1'b1) begin
         bad++;
         $display("[TB] FAIL disable_err_entry: pc=%h err=%b want pc=0000010c err=1", last_pop_pc, last_pop_err);
      end
      g0 = gnt_log.size();
      repeat (3) step(1'b1, 1'b0, 32'h0);
      total++; if (last_busy !== 1'b0) begin bad++; $display("[TB] FAIL disable_idle_busy: got %b want 0", last_busy); end
      total++;
      if (last_req !== 1'b0 || gnt_log.size() != g0) begin
         bad++;
         $display("[TB] FAIL disable_no_fetch: req=%b extra_grants=%0d want 0/0", last_req, gnt_log.size() - g0);
      end
   endtask

   task automatic test_reset_midop();
      logic found;
      int gi, p0;
      rand_lat = 1'b0; gfix = 0; rfix = 2;
      en = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 32'h0);
         if (just_granted) begin found = 1'b1; break; end
      end
      #2;
      rst_n        = 1'b0;
      instr_gnt    = 1'b0;
      fetch_enable = 1'b0;
      en           = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || instr_req !== 1'b0 || instr_valid !== 1'b0 || instr_addr !== 32'h0) begin
         bad++;
         $display("[TB] FAIL midop_reset: busy=%b req=%b valid=%b addr=%h want all 0", busy, instr_req, instr_valid, instr_addr);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) step(1'b1, 1'b0, 32'h0);
      total++;
      if (last_valid !== 1'b0 || last_busy !== 1'b0 || pend) begin
         bad++;
         $display("[TB] FAIL stale_after_reset: valid=%b busy=%b want 0/0", last_valid, last_busy);
      end
      boot_addr = 32'h300;
      exp_pc    = 32'h300;
      en        = 1'b1;
      gi = gnt_log.size();
      p0 = n_pop;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 32'h0);
         if (n_pop > p0) begin found = 1'b1; break; end
      end
      total++;
      if (!found || gnt_log[gi] !== 32'h300 || last_pop_pc !== 32'h300) begin
         bad++;
         $display("[TB] FAIL reboot_addr: req=%h pc=%h want 00000300", found ? gnt_log[gi] : 32'hx, last_pop_pc);
      end
   endtask

   task automatic test_random();
      int p0;
      logic ready, br, found;
      logic [31:0] tgt;
      rand_lat = 1'b1;
      en = 1'b1;
      p0 = n_pop;
      for (int i = 0; i < 1500; i++) begin
         ready = ($urandom_range(0, 9) < 7);
         br    = ($urandom_range(0, 49) == 0);
         tgt   = ($urandom & 32'h0003_FFFC) | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
         if ($urandom_range(0, 39) == 0) en = ~en;
         step(ready, br, tgt);
      end
      en = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step(1'b1, 1'b0, 32'h0);
         if (last_busy === 1'b0 && last_valid === 1'b0 && !pend) begin found = 1'b1; break; end
      end
      total++;
      if (!found) begin bad++; $display("[TB] FAIL random_drain: busy=%b valid=%b want 0/0", last_busy, last_valid); end
      total++;
      if (n_pop - p0 < 50) begin bad++; $display("[TB] FAIL random_progress: %0d pops want >= 50", n_pop - p0); end
   endtask

   initial begin
      test_reset();
      test_boot_fetch();
      test_back_pressure();
      test_redirect_wait();
      test_redirect_grant();
      test_wait_wrap();
      test_disable_error();
      test_reset_midop();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the milano core. It owns the fetch PC, drives the instruction-RAM request/grant/rvalid handshake with at most one request outstanding, and buffers returned instructions in a 2-entry FIFO toward decode. It handles core enable, branch/jump redirects with stale-response discard, and decode back-pressure.

## Interface
- `ADDR_WIDTH`, default 32. Address and PC width. Only 32 is supported.
- `clk_i`  in  1  core clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `boot_addr_i`  in  32  first fetch address after reset
- `fetch_enable_i`  in  1  level; 1 = fetching allowed
- `instr_req_o`  out  1  request to instruction RAM
- `instr_addr_o`  out  32  request address; always equals the current fetch PC
- `instr_gnt_i`  in  1  RAM accepted the request this cycle
- `instr_rvalid_i`  in  1  response valid
- `instr_rdata_i`  in  32  response data
- `instr_err_i`  in  1  response error, qualified by `instr_rvalid_i`
- `branch_i`  in  1  single-cycle redirect pulse from execute
- `branch_target_i`  in  32  redirect PC, qualified by `branch_i`
- `id_ready_i`  in  1  decode accepts the FIFO head this cycle
- `instr_valid_o`  out  1  FIFO not empty
- `instr_o`  out  32  FIFO head instruction
- `pc_o`  out  32  FIFO head address
- `instr_err_o`  out  1  FIFO head error flag
- `busy_o`  out  1  state is not IDLE

## Operation
- **Registers**
  - `pc_q`: fetch PC.
  - `started_q`: set on the first exit from IDLE after reset.
  - `discard_q`: drop the next response.
  - `addr_q`: address of the request in flight.
  - FIFO: 2 entries, each {instr, pc, err}, count 0..2.
- **Reset values:** state IDLE, `pc_q` = 0, `started_q` = 0, `discard_q` = 0, count = 0. All outputs are 0.
- **State IDLE**
  - `instr_req_o` = 0.
  - Go to REQ when `fetch_enable_i` = 1 and count < 2.
  - On that transition, if `started_q` = 0, load `pc_q` from `boot_addr_i`. Otherwise `pc_q` resumes from its held value.
- **State REQ**
  - `instr_req_o` = 1, `instr_addr_o` = `pc_q`.
  - On `instr_gnt_i`: `addr_q` ← `pc_q`, `pc_q` ← `pc_q` + 4 (modulo 2^32, 0xFFFFFFFC wraps to 0), go to WAIT.
- **State WAIT**
  - `instr_req_o` = 0.
  - On `instr_rvalid_i` with `discard_q` = 0: push {`instr_rdata_i`, `addr_q`, `instr_err_i`}.
  - On `instr_rvalid_i` with `discard_q` = 1: drop the response and clear `discard_q`.
  - Next state after the response: REQ if `fetch_enable_i` = 1 and the post-update count < 2, otherwise IDLE.
- **Entry guard:** REQ is entered only with count < 2. Count never increases while a request is outstanding, so a response always finds a free slot.
- **FIFO pop:** `id_ready_i` && `instr_valid_o`. A push and a pop in the same cycle leave count unchanged.
- **Redirect** (`branch_i` = 1), highest priority:
  - `pc_q` ← `branch_target_i`. This overrides the +4, including on a same-cycle grant.
  - FIFO is flushed: count = 0 and any same-cycle push or pop is ignored.
  - If in WAIT, or in REQ with `instr_gnt_i` = 1: `discard_q` ← 1.
  - If in WAIT with `instr_rvalid_i` = 1 in the same cycle: that response is dropped and `discard_q` stays 0.
  - If in REQ without grant: the address changes to the target from the next cycle. The RAM permits address change before grant.
  - If in IDLE: only `pc_q` updates.
- **`fetch_enable_i` deasserted mid-operation**
  - A request in REQ stays asserted until granted.
  - Its response is still accepted (or discarded).
  - Then the block goes to IDLE. The FIFO keeps draining to decode.
- **Errors:** `instr_err_i` is only propagated with the entry. Fetch continues at PC + 4.
- **Misalignment:** a misaligned target is not checked and is fetched as given.

## Timing
- `fetch_enable_i` rising in cycle n (IDLE, count 0) gives `instr_req_o` = 1 in cycle n+1.
- Grant is accepted in the same cycle as the request.
- The earliest `instr_rvalid_i` is the cycle after grant.
- `instr_valid_o` rises the cycle after an accepted `instr_rvalid_i`.
- With a zero-wait RAM (grant same cycle, rvalid +1), throughput is one instruction per 2 cycles; REQ recurs the cycle after rvalid.
- On `branch_i` in cycle n, `instr_valid_o` = 0 in cycle n+1.
- The first target instruction is valid no earlier than n+3 (REQ at n+1, rvalid at n+2), later if a discarded response is still pending.
- `busy_o` is registered with the state.
- Asserting reset mid-operation returns immediately to reset values. An outstanding response arriving after reset release in IDLE is ignored.

## Test plan
- **Boot fetch:** `boot_addr_i` = 0x0000_0080, enable after reset, zero-wait RAM → requests at 0x80, 0x84, 0x88. Decode sees `pc_o` 0x80/0x84/0x88 with matching data, one instruction every 2 cycles.
- **Back-pressure:** `id_ready_i` = 0 for 10 cycles → exactly 2 entries buffered, `instr_req_o` stays 0, no data lost. Release → in-order delivery, then fetch resumes at the next PC.
- **Redirect in WAIT:** `branch_i` with target 0x200 while the request for 0x90 is outstanding → the 0x90 response is dropped, FIFO empty next cycle, next request is 0x200, `pc_o` = 0x200.
- **Redirect on grant cycle:** `branch_i` coincides with `instr_gnt_i` for 0x40, target 0x1000 → `pc_q` = 0x1000, the 0x40 response is discarded, no +4 applied.
- **Wait states and wrap:** `instr_gnt_i` delayed 3 cycles with `pc_q` = 0xFFFF_FFFC → `instr_addr_o` held stable until grant, next request is 0x0000_0000.
- **Disable and error:** drop `fetch_enable_i` while in REQ → request held until grant, response delivered, then IDLE with `busy_o` = 0. A response carrying `instr_err_i` = 1 reaches decode with `instr_err_o` = 1.
